// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm-clock controller.
//   Stores an alarm time (stepped by set_hour/set_min), compares it against the
//   running time of day on each one-second tick, and sequences the ring,
//   snooze and stop behaviour. The buzzer is driven 1 s on / 1 s off while
//   ringing.
// Ports:
//   clk               system clock, all state on posedge
//   clrn              asynchronous active-low reset
//   tick_1s           one-cycle pulse per second
//   h, m, s           current time of day (h 0..23, m/s 0..59)
//   alarm_en          level; low disables the alarm and forces idle
//   set_hour, set_min single-cycle pulses stepping the alarm time
//   stop, snooze      single-cycle pulses
//   alarm_h, alarm_m  stored alarm time (registered)
//   ringing, snoozing registered status
//   buzz              registered buzzer drive
module alarm_ctrl #(
    parameter int DEFAULT_H   = 7,
    parameter int DEFAULT_M   = 0,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick_1s,
    input  logic [5:0] h,
    input  logic [5:0] m,
    input  logic [5:0] s,
    input  logic       alarm_en,
    input  logic       set_hour,
    input  logic       set_min,
    input  logic       stop,
    input  logic       snooze,
    output logic [5:0] alarm_h,
    output logic [5:0] alarm_m,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzz
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZE  = 2'd2;

    localparam logic [5:0] DEF_H       = 6'(DEFAULT_H);
    localparam logic [5:0] DEF_M       = 6'(DEFAULT_M);
    localparam logic [5:0] RING_LAST   = 6'(RING_SECS - 1);
    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS);

    logic [1:0] state_r;
    logic [1:0] state_nx_s;
    logic [5:0] ring_cnt_r;
    logic [5:0] ring_cnt_nx_s;
    logic [8:0] snz_cnt_r;
    logic [8:0] snz_cnt_nx_s;
    logic       phase_r;
    logic       phase_nx_s;
    logic [5:0] alarm_h_nx_s;
    logic [5:0] alarm_m_nx_s;
    logic       match_s;

    // Match uses the alarm time held this cycle, before any set pulse lands.
    assign match_s = tick_1s && alarm_en && (h == alarm_h) && (m == alarm_m) && (s == 6'd0);

    // Alarm time stepping: hour wraps 23->0, minute wraps 59->0.
    always_comb begin
        alarm_h_nx_s = alarm_h;
        alarm_m_nx_s = alarm_m;
        if (set_hour) begin
            alarm_h_nx_s = (alarm_h == 6'd23) ? 6'd0 : alarm_h + 6'd1;
        end else begin
            alarm_h_nx_s = alarm_h;
        end
        if (set_min) begin
            alarm_m_nx_s = (alarm_m == 6'd59) ? 6'd0 : alarm_m + 6'd1;
        end else begin
            alarm_m_nx_s = alarm_m;
        end
    end

    // Ring/snooze sequencer: alarm_en, then stop, then snooze, then tick events.
    always_comb begin
        state_nx_s    = state_r;
        ring_cnt_nx_s = ring_cnt_r;
        snz_cnt_nx_s  = snz_cnt_r;
        phase_nx_s    = phase_r;
        if (!alarm_en) begin
            state_nx_s = ST_IDLE;
            phase_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (match_s) begin
                        state_nx_s    = ST_RINGING;
                        ring_cnt_nx_s = 6'd0;
                        phase_nx_s    = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_RINGING: begin
                    if (stop) begin
                        state_nx_s = ST_IDLE;
                        phase_nx_s = 1'b0;
                    end else if (snooze) begin
                        state_nx_s   = ST_SNOOZE;
                        snz_cnt_nx_s = SNOOZE_LOAD;
                        phase_nx_s   = 1'b0;
                    end else if (tick_1s) begin
                        if (ring_cnt_r == RING_LAST) begin
                            state_nx_s = ST_IDLE;
                            phase_nx_s = 1'b0;
                        end else begin
                            ring_cnt_nx_s = ring_cnt_r + 6'd1;
                            phase_nx_s    = ~phase_r;
                        end
                    end else begin
                        state_nx_s = ST_RINGING;
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        state_nx_s = ST_IDLE;
                    end else if (tick_1s) begin
                        if (snz_cnt_r == 9'd1) begin
                            state_nx_s    = ST_RINGING;
                            ring_cnt_nx_s = 6'd0;
                            phase_nx_s    = 1'b1;
                        end else begin
                            snz_cnt_nx_s = snz_cnt_r - 9'd1;
                        end
                    end else begin
                        state_nx_s = ST_SNOOZE;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    phase_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State, counters, alarm time and registered status outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r    <= ST_IDLE;
            ring_cnt_r <= 6'd0;
            snz_cnt_r  <= 9'd0;
            phase_r    <= 1'b0;
            alarm_h    <= DEF_H;
            alarm_m    <= DEF_M;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            buzz       <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ring_cnt_r <= ring_cnt_nx_s;
            snz_cnt_r  <= snz_cnt_nx_s;
            phase_r    <= phase_nx_s;
            alarm_h    <= alarm_h_nx_s;
            alarm_m    <= alarm_m_nx_s;
            ringing    <= (state_nx_s == ST_RINGING);
            snoozing   <= (state_nx_s == ST_SNOOZE);
            buzz       <= phase_nx_s && (state_nx_s == ST_RINGING);
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: self-checking bench for alarm_ctrl (default parameters).
// A behavioural model predicts the outputs for every driven cycle; the
// prediction is queued and compared once the DUT has clocked. A vector table
// covers single-cycle decisions; hand sequences cover ring length, snooze
// length, wrap-around of the alarm time and asynchronous reset.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       clrn;
    logic       tick_1s, alarm_en, set_hour, set_min, stop, snooze;
    logic [5:0] h, m, s;
    logic [5:0] alarm_h, alarm_m;
    logic       ringing, snoozing, buzz;

    alarm_ctrl dut (
        .clk(clk), .clrn(clrn), .tick_1s(tick_1s), .h(h), .m(m), .s(s),
        .alarm_en(alarm_en), .set_hour(set_hour), .set_min(set_min),
        .stop(stop), .snooze(snooze), .alarm_h(alarm_h), .alarm_m(alarm_m),
        .ringing(ringing), .snoozing(snoozing), .buzz(buzz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] ah;
        logic [5:0] am;
        logic       r;
        logic       sn;
        logic       bz;
    } exp_t;

    typedef struct {
        bit sh, sm, st, sz, tk;
        int hh, mm, ss;
        bit en;
        bit r, sn, bz;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state (0 idle, 1 ringing, 2 snooze).
    int mst, mring, msnz, mah, mam;
    bit mph;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mst = 0; mring = 0; msnz = 0; mph = 0; mah = 7; mam = 0;
    endtask

    task automatic model_step(input bit sh, sm, st, sz, tk, input int hh, mm, ss, input bit en);
        bit match;
        match = tk && en && hh == mah && mm == mam && ss == 0;
        if (!en) begin
            mst = 0; mph = 0;
        end else if (mst == 0) begin
            if (match) begin mst = 1; mring = 0; mph = 1; end
        end else if (mst == 1) begin
            if (st) begin mst = 0; mph = 0; end
            else if (sz) begin mst = 2; msnz = 300; mph = 0; end
            else if (tk) begin
                if (mring == 59) begin mst = 0; mph = 0; end
                else begin mring++; mph = !mph; end
            end
        end else begin
            if (st) mst = 0;
            else if (tk) begin
                if (msnz == 1) begin mst = 1; mring = 0; mph = 1; end
                else msnz--;
            end
        end
        if (sh) mah = (mah + 1) % 24;
        if (sm) mam = (mam + 1) % 60;
    endtask

    // Drive one cycle, queue the model's prediction, compare after the edge.
    task automatic apply(input bit sh, sm, st, sz, tk, input int hh, mm, ss, input bit en);
        exp_t e, a;
        set_hour = sh; set_min = sm; stop = st; snooze = sz; tick_1s = tk;
        h = 6'(hh); m = 6'(mm); s = 6'(ss); alarm_en = en;
        model_step(sh, sm, st, sz, tk, hh, mm, ss, en);
        e.ah = 6'(mah); e.am = 6'(mam); e.r = (mst == 1); e.sn = (mst == 2); e.bz = mph && (mst == 1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        a = {alarm_h, alarm_m, ringing, snoozing, buzz};
        e = sb_q.pop_front();
        check("scoreboard", int'(a), int'(e));
    endtask

    task automatic idle_cycle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);
    endtask

    vec_t tbl[13];

    initial begin
        int n;
        clrn = 1'b0;
        {tick_1s, set_hour, set_min, stop, snooze} = 5'd0;
        alarm_en = 1'b1; h = 6'd0; m = 6'd0; s = 6'd0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", int'({alarm_h, alarm_m, ringing, snoozing, buzz}), int'({6'd7, 6'd0, 3'b000}));
        clrn = 1'b1;

        // Alarm time stepping and wrap-around.
        for (int i = 0; i < 7; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);
        for (int i = 0; i < 30; i++) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);
        check("set_to_14h", int'(alarm_h), 14);
        check("set_to_30m", int'(alarm_m), 30);
        for (int i = 0; i < 9; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);
        check("hour_at_23", int'(alarm_h), 23);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);
        check("hour_wrap", int'(alarm_h), 0);
        for (int i = 0; i < 29; i++) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);
        check("min_at_59", int'(alarm_m), 59);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);
        check("min_wrap", int'(alarm_m), 0);
        for (int i = 0; i < 7; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);

        // Single-cycle decisions with the alarm at 07:00.
        //          sh sm st sz tk  h  m  s en   r sn bz
        tbl[0]  = '{0, 0, 0, 0, 1, 7, 0, 1, 1,  0, 0, 0}; // s=1: no match
        tbl[1]  = '{0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 0, 0}; // disabled: no match
        tbl[2]  = '{0, 0, 0, 0, 0, 7, 0, 0, 1,  0, 0, 0}; // no tick
        tbl[3]  = '{0, 0, 0, 0, 1, 8, 0, 0, 1,  0, 0, 0}; // wrong hour
        tbl[4]  = '{0, 0, 0, 0, 1, 7, 0, 0, 1,  1, 0, 1}; // match
        tbl[5]  = '{0, 0, 1, 1, 0, 7, 0, 1, 1,  0, 0, 0}; // stop beats snooze
        tbl[6]  = '{0, 0, 0, 0, 1, 7, 0, 0, 1,  1, 0, 1}; // match again
        tbl[7]  = '{0, 0, 0, 0, 1, 7, 0, 1, 1,  1, 0, 0}; // buzz toggles off
        tbl[8]  = '{0, 0, 0, 1, 0, 7, 0, 1, 1,  0, 1, 0}; // snooze
        tbl[9]  = '{0, 0, 0, 1, 1, 7, 0, 2, 1,  0, 1, 0}; // snooze ignored
        tbl[10] = '{0, 0, 0, 0, 0, 7, 0, 3, 0,  0, 0, 0}; // disable in snooze
        tbl[11] = '{0, 0, 0, 0, 1, 7, 0, 0, 1,  1, 0, 1}; // match
        tbl[12] = '{0, 0, 1, 0, 1, 7, 0, 1, 1,  0, 0, 0}; // stop with tick
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].sh, tbl[i].sm, tbl[i].st, tbl[i].sz, tbl[i].tk,
                  tbl[i].hh, tbl[i].mm, tbl[i].ss, tbl[i].en);
            check($sformatf("vec%0d", i), int'({ringing, snoozing, buzz}),
                  int'({tbl[i].r, tbl[i].sn, tbl[i].bz}));
        end

        // Ring auto-stops after RING_SECS ticks, buzz alternating.
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 0, 0, 1'b1);
        check("ring_start", int'({ringing, buzz}), 3);
        n = 0;
        for (int i = 1; i <= 70; i++) begin
            idle_cycle();
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 1, (i % 59) + 1, 1'b1);
            if (!ringing) begin n = i; break; end
        end
        check("ring_len", n, 60);

        // Snooze countdown of SNOOZE_SECS ticks; a snooze pulse mid-count is ignored.
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 0, 0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7, 0, 1, 1'b1);
        check("snooze_enter", int'({ringing, snoozing}), 1);
        n = 0;
        for (int i = 1; i <= 310; i++) begin
            if (i == 150) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7, 2, 1, 1'b1);
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 2, (i % 59) + 1, 1'b1);
            if (ringing) begin n = i; break; end
        end
        check("snooze_len", n, 300);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7, 7, 7, 1'b1);
        check("stop_all", int'({ringing, snoozing, buzz}), 0);

        // Asynchronous reset mid-ring with alarm at 12:34.
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);
        for (int i = 0; i < 34; i++) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12, 34, 0, 1'b1);
        check("ring_1234", int'(ringing), 1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12, 34, 1, 1'b1);
        #2;
        clrn = 1'b0;
        #1;
        check("async_reset", int'({alarm_h, alarm_m, ringing, snoozing, buzz}), int'({6'd7, 6'd0, 3'b000}));
        model_reset();
        @(posedge clk);
        #1;
        clrn = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12, 34, 0, 1'b1);
        check("no_ring_after_reset", int'(ringing), 0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 0, 0, 1'b1);
        check("ring_new_match", int'(ringing), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_H, default 7, alarm hour loaded at reset (0..23).
REQ-002 SHALL have parameter DEFAULT_M, default 0, alarm minute loaded at reset (0..59).
REQ-003 SHALL have parameter RING_SECS, default 60, auto-stop ring duration in seconds (1..63).
REQ-004 SHALL have parameter SNOOZE_SECS, default 300, snooze delay in seconds (1..511).
REQ-005 SHALL have port clk  input  1  system clock, single clock domain, all state on posedge clk.
REQ-006 SHALL have port clrn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port tick_1s  input  1  one-clk-cycle pulse per second, clk-synchronous, from the clock stage's divider.
REQ-008 SHALL have ports h, m, s  input  6 each  current time from the time-of-day counter (h 0..23, m/s 0..59).
REQ-009 SHALL have port alarm_en  input  1  level; 0 disables the alarm and forces IDLE.
REQ-010 SHALL have ports set_hour, set_min  input  1 each  single-cycle debounced pulses that step the alarm time.
REQ-011 SHALL have ports stop, snooze  input  1 each  single-cycle debounced pulses.
REQ-012 SHALL have ports alarm_h, alarm_m  output  6 each  stored alarm time, registered.
REQ-013 SHALL have ports ringing, snoozing, buzz  output  1 each  registered status and buzzer drive.

Function
REQ-014 SHALL implement FSM states IDLE, RINGING, SNOOZE; ringing=1 only in RINGING, snoozing=1 only in SNOOZE.
REQ-015 set_hour SHALL set alarm_h <= (alarm_h+1) mod 24 next cycle; set_min SHALL set alarm_m <= (alarm_m+1) mod 60; both accepted in every state, neither changes FSM state.
REQ-016 Match SHALL be true in a cycle where tick_1s=1, alarm_en=1, h==alarm_h, m==alarm_m, s==0, using h/m/s/alarm values present in that cycle (pre-update).
REQ-017 IDLE -> RINGING on match; ring counter cleared, buzz phase set to 1 on entry.
REQ-018 RINGING: ring counter SHALL increment on each tick_1s; on the tick where counter == RING_SECS-1, go IDLE.
REQ-019 RINGING: stop -> IDLE next cycle; snooze (without stop) -> SNOOZE, snooze counter loaded with SNOOZE_SECS.
REQ-020 SNOOZE: counter SHALL decrement on each tick_1s; on the tick where counter == 1, go RINGING (ring counter cleared, buzz phase 1); snooze pulses ignored; stop -> IDLE.
REQ-021 stop and snooze in the same cycle: stop SHALL win.
REQ-022 alarm_en=0 in any state SHALL force IDLE next cycle, overriding all other inputs.
REQ-023 stop or tick_1s coinciding with a transition condition: stop/alarm_en handled first, then tick events; only one transition per cycle.
REQ-024 buzz SHALL equal buzz phase AND ringing; phase toggles on each tick_1s while RINGING, giving 1 s on / 1 s off starting with on.
REQ-025 Match in RINGING or SNOOZE SHALL be ignored (no restart of counters).
REQ-026 Ring counter width 6 bits, snooze counter 9 bits; no wrap beyond stated terminal values.
REQ-027 Latency: state/outputs SHALL change on the clk edge following the qualifying input cycle (1 cycle).

Reset
REQ-028 clrn=0 SHALL asynchronously force IDLE, alarm_h=DEFAULT_H, alarm_m=DEFAULT_M, ringing=0, snoozing=0, buzz=0, both counters 0, buzz phase 0.
REQ-029 Reset asserted mid-RINGING or mid-SNOOZE SHALL abandon the sequence; after release, ringing resumes only on a new match.

Verification
REQ-030 Reset, then 7 set_hour pulses and 30 set_min pulses -> alarm_h=14, alarm_m=30; from alarm_h=23 one set_hour -> 0; from alarm_m=59 one set_min -> 0.
REQ-031 alarm=07:00, alarm_en=1, tick with h=7,m=0,s=0 -> ringing=1, buzz=1 next cycle; buzz toggles each tick; after 60 ticks ringing=0 with no stop.
REQ-032 Ringing, snooze pulse -> snoozing=1, ringing=0; after 300 ticks -> ringing=1 again; then stop -> IDLE, all status 0.
REQ-033 stop and snooze same cycle while ringing -> IDLE; snooze pulse in SNOOZE -> countdown unchanged.
REQ-034 alarm_en dropped during SNOOZE -> IDLE next cycle; match with alarm_en=0 or s=1 -> no ring.
REQ-035 clrn pulsed low mid-RINGING with alarm set to 12:34 -> outputs 0 immediately, alarm_h=7, alarm_m=0 after reset.
